// File: rtl/uarch_pkg.sv
// Shared micro-architecture definitions for the issue queue slice.
// Op codes and default payload field widths.
package uarch_pkg;

  localparam int OPT_W    = 4;
  localparam int XLEN_D   = 32;
  localparam int PTAG_D   = 6;
  localparam int ROB_D    = 6;
  localparam int DEPTH_D  = 16;
  localparam int NUM_FU_D = 3;
  localparam int NUM_WB_D = 3;

  typedef enum logic [OPT_W-1:0] {
    OP_NONE = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_SLL  = 4'd6,
    OP_SRL  = 4'd7,
    OP_SRA  = 4'd8,
    OP_SLT  = 4'd9,
    OP_ADDI = 4'd10,
    OP_LUI  = 4'd11,
    OP_BEQ  = 4'd12,
    OP_BNE  = 4'd13,
    OP_LW   = 4'd14,
    OP_SW   = 4'd15
  } op_e;

endpackage

// File: rtl/iq_age_select.sv
// Oldest-first picker: grants the requester that has no
// older requester according to the age matrix.
module iq_age_select
  import uarch_pkg::*;
#(
  parameter int DEPTH = DEPTH_D
) (
  input  logic [DEPTH-1:0]       req,
  input  logic [DEPTH*DEPTH-1:0] age,
  output logic [DEPTH-1:0]       gnt,
  output logic                   any
);

  // col[i][j] set when entry j is older than entry i
  logic [DEPTH-1:0] col [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      col[i] = '0;
      for (int j = 0; j < DEPTH; j++) begin
        col[i][j] = age[j*DEPTH+i];
      end
    end
  end

  always_comb begin
    gnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      gnt[i] = req[i] & ~(|(req & col[i]));
    end
  end

  assign any = |req;

endmodule

// File: rtl/issue_queue_param.sv
// Parametrised unified issue queue: wakeup CAM, age-ordered
// per-FU select, round-robin FU binding and flush.
module issue_queue_param
  import uarch_pkg::*;
#(
  parameter int DEPTH  = DEPTH_D,
  parameter int NUM_FU = NUM_FU_D,
  parameter int NUM_WB = NUM_WB_D,
  parameter int XLEN   = XLEN_D,
  parameter int PTAG_W = PTAG_D,
  parameter int ROB_W  = ROB_D
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  logic [XLEN-1:0]          disp_pc,
  input  logic [OPT_W-1:0]         disp_optype,
  input  logic [PTAG_W-1:0]        disp_src1_tag,
  input  logic                     disp_src1_rdy,
  input  logic [XLEN-1:0]          disp_src1_data,
  input  logic [PTAG_W-1:0]        disp_src2_tag,
  input  logic                     disp_src2_rdy,
  input  logic [XLEN-1:0]          disp_src2_data,
  input  logic [XLEN-1:0]          disp_imm,
  input  logic [PTAG_W-1:0]        disp_dst_tag,
  input  logic [ROB_W-1:0]         disp_rob_idx,
  input  logic [NUM_WB-1:0]        wb_valid,
  input  logic [NUM_WB*PTAG_W-1:0] wb_tag,
  input  logic [NUM_WB*XLEN-1:0]   wb_data,
  input  logic [NUM_FU-1:0]        fu_ready,
  output logic [NUM_FU-1:0]        iss_valid,
  output logic [NUM_FU*XLEN-1:0]   iss_pc,
  output logic [NUM_FU*OPT_W-1:0]  iss_optype,
  output logic [NUM_FU*XLEN-1:0]   iss_src1,
  output logic [NUM_FU*XLEN-1:0]   iss_src2,
  output logic [NUM_FU*XLEN-1:0]   iss_imm,
  output logic [NUM_FU*PTAG_W-1:0] iss_dst_tag,
  output logic [NUM_FU*ROB_W-1:0]  iss_rob_idx,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CW    = IDX_W + 1;
  localparam int FU_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [FU_W-1:0] FU_MAX  = FU_W'(NUM_FU - 1);

  logic [DEPTH-1:0]  valid;
  logic [DEPTH-1:0]  s1_rdy;
  logic [DEPTH-1:0]  s2_rdy;
  logic [DEPTH-1:0]  age [DEPTH];
  logic [XLEN-1:0]   e_pc  [DEPTH];
  logic [XLEN-1:0]   e_s1  [DEPTH];
  logic [XLEN-1:0]   e_s2  [DEPTH];
  logic [XLEN-1:0]   e_imm [DEPTH];
  logic [OPT_W-1:0]  e_op  [DEPTH];
  logic [PTAG_W-1:0] e_t1  [DEPTH];
  logic [PTAG_W-1:0] e_t2  [DEPTH];
  logic [PTAG_W-1:0] e_dst [DEPTH];
  logic [ROB_W-1:0]  e_rob [DEPTH];
  logic [FU_W-1:0]   e_fu  [DEPTH];
  logic [FU_W-1:0]   rr;

  logic              accept;
  logic [IDX_W-1:0]  alloc_idx;
  logic [DEPTH-1:0]  alloc_oh;
  logic [DEPTH-1:0]  issued;
  logic [CW-1:0]     n_iss;
  logic [CW-1:0]     occ_next;

  assign disp_ready = rstn && (occupancy < DEPTH_C)
                      && !flush;
  assign accept = disp_valid && disp_ready
                  && (disp_optype != OP_NONE);

  always_comb begin
    alloc_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) alloc_idx = IDX_W'(i);
    end
  end

  assign alloc_oh = accept ? (DEPTH'(1) << alloc_idx)
                           : '0;

  // Wakeup CAM; walking ports downward lets the lowest port win
  logic [DEPTH-1:0] wk1, wk2;
  logic [XLEN-1:0]  wk1_d [DEPTH];
  logic [XLEN-1:0]  wk2_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wk1[i]   = 1'b0;
      wk2[i]   = 1'b0;
      wk1_d[i] = '0;
      wk2_d[i] = '0;
      for (int w = NUM_WB - 1; w >= 0; w--) begin
        if (wb_valid[w] &&
            wb_tag[w*PTAG_W +: PTAG_W] == e_t1[i]) begin
          wk1[i]   = 1'b1;
          wk1_d[i] = wb_data[w*XLEN +: XLEN];
        end
        if (wb_valid[w] &&
            wb_tag[w*PTAG_W +: PTAG_W] == e_t2[i]) begin
          wk2[i]   = 1'b1;
          wk2_d[i] = wb_data[w*XLEN +: XLEN];
        end
      end
    end
  end

  logic            by1, by2;
  logic [XLEN-1:0] by1_d, by2_d;

  always_comb begin
    by1   = 1'b0;
    by2   = 1'b0;
    by1_d = '0;
    by2_d = '0;
    for (int w = NUM_WB - 1; w >= 0; w--) begin
      if (wb_valid[w] &&
          wb_tag[w*PTAG_W +: PTAG_W] == disp_src1_tag) begin
        by1   = 1'b1;
        by1_d = wb_data[w*XLEN +: XLEN];
      end
      if (wb_valid[w] &&
          wb_tag[w*PTAG_W +: PTAG_W] == disp_src2_tag) begin
        by2   = 1'b1;
        by2_d = wb_data[w*XLEN +: XLEN];
      end
    end
  end

  logic [DEPTH*DEPTH-1:0]          age_flat;
  logic [NUM_FU-1:0][DEPTH-1:0]    req;
  logic [NUM_FU-1:0][DEPTH-1:0]    gnt;
  logic [NUM_FU-1:0]               any;
  logic [NUM_FU-1:0]               fire;

  always_comb begin
    age_flat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        age_flat[i*DEPTH+j] = age[i][j];
      end
    end
  end

  always_comb begin
    req = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      for (int i = 0; i < DEPTH; i++) begin
        req[f][i] = valid[i] & s1_rdy[i] & s2_rdy[i]
                    & (e_fu[i] == FU_W'(f));
      end
    end
  end

  for (genvar gf = 0; gf < NUM_FU; gf++) begin : g_sel
    iq_age_select #(
      .DEPTH (DEPTH)
    ) u_sel (
      .req (req[gf]),
      .age (age_flat),
      .gnt (gnt[gf]),
      .any (any[gf])
    );
  end

  assign fire = any & fu_ready;

  // One-hot grant turns the payload mux into AND-OR
  logic [XLEN-1:0]   sp_pc  [NUM_FU];
  logic [XLEN-1:0]   sp_s1  [NUM_FU];
  logic [XLEN-1:0]   sp_s2  [NUM_FU];
  logic [XLEN-1:0]   sp_imm [NUM_FU];
  logic [OPT_W-1:0]  sp_op  [NUM_FU];
  logic [PTAG_W-1:0] sp_dst [NUM_FU];
  logic [ROB_W-1:0]  sp_rob [NUM_FU];

  always_comb begin
    issued = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      sp_pc[f]  = '0;
      sp_s1[f]  = '0;
      sp_s2[f]  = '0;
      sp_imm[f] = '0;
      sp_op[f]  = '0;
      sp_dst[f] = '0;
      sp_rob[f] = '0;
      if (fire[f]) issued = issued | gnt[f];
      for (int i = 0; i < DEPTH; i++) begin
        if (gnt[f][i]) begin
          sp_pc[f]  = sp_pc[f]  | e_pc[i];
          sp_s1[f]  = sp_s1[f]  | e_s1[i];
          sp_s2[f]  = sp_s2[f]  | e_s2[i];
          sp_imm[f] = sp_imm[f] | e_imm[i];
          sp_op[f]  = sp_op[f]  | e_op[i];
          sp_dst[f] = sp_dst[f] | e_dst[i];
          sp_rob[f] = sp_rob[f] | e_rob[i];
        end
      end
    end
  end

  always_comb begin
    n_iss = '0;
    for (int i = 0; i < DEPTH; i++) begin
      n_iss = n_iss + CW'(issued[i]);
    end
  end

  assign occ_next = occupancy + CW'(accept) - n_iss;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid       <= '0;
      rr          <= '0;
      occupancy   <= '0;
      iss_valid   <= '0;
      iss_pc      <= '0;
      iss_optype  <= '0;
      iss_src1    <= '0;
      iss_src2    <= '0;
      iss_imm     <= '0;
      iss_dst_tag <= '0;
      iss_rob_idx <= '0;
      for (int i = 0; i < DEPTH; i++) age[i] <= '0;
    end else if (flush) begin
      valid     <= '0;
      rr        <= '0;
      occupancy <= '0;
      iss_valid <= '0;
      for (int i = 0; i < DEPTH; i++) age[i] <= '0;
    end else begin
      occupancy <= occ_next;
      iss_valid <= fire;
      valid     <= (valid & ~issued) | alloc_oh;
      if (accept) begin
        rr <= (rr == FU_MAX) ? '0 : rr + 1'b1;
        // new entry is younger than everything live
        age[alloc_idx] <= '0;
        for (int j = 0; j < DEPTH; j++) begin
          age[j][alloc_idx] <= valid[j];
        end
      end
      for (int f = 0; f < NUM_FU; f++) begin
        if (fire[f]) begin
          iss_pc[f*XLEN +: XLEN]          <= sp_pc[f];
          iss_optype[f*OPT_W +: OPT_W]    <= sp_op[f];
          iss_src1[f*XLEN +: XLEN]        <= sp_s1[f];
          iss_src2[f*XLEN +: XLEN]        <= sp_s2[f];
          iss_imm[f*XLEN +: XLEN]         <= sp_imm[f];
          iss_dst_tag[f*PTAG_W +: PTAG_W] <= sp_dst[f];
          iss_rob_idx[f*ROB_W +: ROB_W]   <= sp_rob[f];
        end
      end
    end
  end

  // Entry payload is qualified by valid, so it needs no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && !s1_rdy[i] && wk1[i]) begin
        s1_rdy[i] <= 1'b1;
        e_s1[i]   <= wk1_d[i];
      end
      if (valid[i] && !s2_rdy[i] && wk2[i]) begin
        s2_rdy[i] <= 1'b1;
        e_s2[i]   <= wk2_d[i];
      end
    end
    if (accept) begin
      e_pc[alloc_idx]   <= disp_pc;
      e_op[alloc_idx]   <= disp_optype;
      e_imm[alloc_idx]  <= disp_imm;
      e_t1[alloc_idx]   <= disp_src1_tag;
      e_t2[alloc_idx]   <= disp_src2_tag;
      e_dst[alloc_idx]  <= disp_dst_tag;
      e_rob[alloc_idx]  <= disp_rob_idx;
      e_fu[alloc_idx]   <= rr;
      s1_rdy[alloc_idx] <= disp_src1_rdy | by1;
      s2_rdy[alloc_idx] <= disp_src2_rdy | by2;
      e_s1[alloc_idx]   <= disp_src1_rdy ? disp_src1_data
                                         : by1_d;
      e_s2[alloc_idx]   <= disp_src2_rdy ? disp_src2_data
                                         : by2_d;
    end
  end

endmodule
